// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port synchronous register file.
package regfile_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int unsigned MaxW     = 256;
    localparam int unsigned MaxBytes = MaxW / 8;

    function automatic logic [MaxW-1:0] byte_merge(input logic [MaxW-1:0]     old_word,
                                                   input logic [MaxW-1:0]     new_word,
                                                   input logic [MaxBytes-1:0] be);
        logic [MaxW-1:0] res;
        for (int unsigned k = 0; k < MaxBytes; k++) begin
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks a pointer over every entry, one per cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic         clr_active,
    output logic [M-1:0] clr_ptr,
    output logic         clr_last
);

    clr_state_e   state_q;
    logic [M-1:0] ptr_q;
    logic         busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clr_active = (state_q == CLEAR);
    assign clr_last   = clr_active && (32'(ptr_q) == N - 1);
    assign clr_ptr    = ptr_q;
    assign clr_busy   = busy_q;

endmodule

// File: rtl/register_file_mp_sync.sv
// Multi-port register file: one byte-enabled write port with write-first bypass,
// R registered read ports, and a built-in sequential clear engine.
module register_file_mp_sync
    import regfile_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned N = 16,
    parameter int unsigned W = 32,
    parameter int unsigned R = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [M-1:0]   wr_addr,
    input  logic [W/8-1:0] wr_be,
    input  logic [W-1:0]   din,
    input  logic [R-1:0]   rd_en,
    input  logic [R*M-1:0] rd_addr,
    output logic [R*W-1:0] dout,
    output logic [R-1:0]   rd_valid,
    input  logic           clr_req,
    output logic           clr_busy,
    output logic           clr_done
);

    logic [W-1:0] mem_q [N];

    logic         clr_active;
    logic         clr_last;
    logic [M-1:0] clr_ptr;

    regfile_clear_fsm #(
        .M (M),
        .N (N)
    ) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_active (clr_active),
        .clr_ptr    (clr_ptr),
        .clr_last   (clr_last)
    );

    // The done pulse is exactly the cycle the engine zeroes the final entry.
    assign clr_done = clr_last;

    logic         wr_acc;
    logic [W-1:0] wr_merged;

    assign wr_acc    = wr_en && !clr_active && (32'(wr_addr) < N);
    assign wr_merged = W'(byte_merge(MaxW'(mem_q[wr_addr]), MaxW'(din), MaxBytes'(wr_be)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N; j++) begin
                mem_q[j] <= '0;
            end
        end else if (clr_active) begin
            mem_q[clr_ptr] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    for (genvar i = 0; i < R; i++) begin : g_rd
        logic [M-1:0] addr;
        logic [W-1:0] word;
        logic [W-1:0] dout_q;
        logic         valid_q;

        assign addr = rd_addr[i*M +: M];

        // Out-of-range addresses read as zero; the entry being cleared reads as zero.
        always_comb begin
            word = '0;
            if (32'(addr) < N) begin
                if (clr_active) begin
                    word = (addr == clr_ptr) ? '0 : mem_q[addr];
                end else if (wr_acc && (addr == wr_addr)) begin
                    word = wr_merged;
                end else begin
                    word = mem_q[addr];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_en[i];
                if (rd_en[i]) begin
                    dout_q <= word;
                end
            end
        end

        assign dout[i*W +: W] = dout_q;
        assign rd_valid[i]    = valid_q;
    end

endmodule

// File: tb/tb_register_file_mp_sync.sv
// Randomized scoreboard bench for register_file_mp_sync against a behavioural array model.
module tb_register_file_mp_sync;

    localparam int unsigned M  = 4;
    localparam int unsigned NM = 16;
    localparam int unsigned W  = 32;
    localparam int unsigned R  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [M-1:0]   wr_addr;
    logic [W/8-1:0] wr_be;
    logic [W-1:0]   din;
    logic [R-1:0]   rd_en;
    logic [R*M-1:0] rd_addr;
    logic [R*W-1:0] dout;
    logic [R-1:0]   rd_valid;
    logic           clr_req;
    logic           clr_busy;
    logic           clr_done;

    logic           s_wr_en;
    logic [M-1:0]   s_wr_addr;
    logic [W/8-1:0] s_wr_be;
    logic [W-1:0]   s_din;
    logic [R-1:0]   s_rd_en;
    logic [R*M-1:0] s_rd_addr;
    logic [R*W-1:0] s_dout;
    logic [R-1:0]   s_rd_valid;
    logic           s_clr_req;
    logic           s_clr_busy;
    logic           s_clr_done;

    always #5 clk = ~clk;

    register_file_mp_sync #(.M(M), .N(NM), .W(W), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout), .rd_valid(rd_valid),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    // Second instance with a non-power-of-two depth.
    register_file_mp_sync #(.M(M), .N(12), .W(W), .R(R)) dut12 (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_be(s_wr_be),
        .din(s_din), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .dout(s_dout), .rd_valid(s_rd_valid),
        .clr_req(s_clr_req), .clr_busy(s_clr_busy), .clr_done(s_clr_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [R*W-1:0] dout;
        logic [R-1:0]   vld;
        logic           busy;
        logic           done;
    } exp_t;

    exp_t q[$];
    exp_t q12[$];

    // Reference model: plain array, clear modelled as a walking index.
    logic [W-1:0] mem_m [NM];
    logic [W-1:0] dout_m [R];
    bit           clr_m;
    int unsigned  ptr_m;

    function automatic logic [W-1:0] merge_w(input logic [W-1:0] o, input logic [W-1:0] n,
                                             input logic [W/8-1:0] be);
        logic [W-1:0] r = o;
        for (int k = 0; k < W/8; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NM; k++) mem_m[k] = '0;
        for (int p = 0; p < R; p++) dout_m[p] = '0;
        clr_m = 0;
        ptr_m = 0;
    endtask

    task automatic step();
        exp_t        e;
        int unsigned a;
        int unsigned wa;
        bit          wacc;
        wa   = 32'(wr_addr);
        wacc = !clr_m && wr_en && (wa < NM);
        for (int p = 0; p < R; p++) begin
            if (rd_en[p]) begin
                a = 32'(rd_addr[p*M +: M]);
                if (a >= NM)                 dout_m[p] = '0;
                else if (clr_m && a == ptr_m) dout_m[p] = '0;
                else if (wacc && a == wa)     dout_m[p] = merge_w(mem_m[a], din, wr_be);
                else                          dout_m[p] = mem_m[a];
            end
        end
        if (wacc) mem_m[wa] = merge_w(mem_m[wa], din, wr_be);
        if (clr_m) begin
            mem_m[ptr_m] = '0;
            if (ptr_m == NM - 1) begin
                clr_m = 0;
                ptr_m = 0;
            end else begin
                ptr_m++;
            end
        end else if (clr_req) begin
            clr_m = 1;
            ptr_m = 0;
        end
        for (int p = 0; p < R; p++) e.dout[p*W +: W] = dout_m[p];
        e.vld  = rd_en;
        e.busy = clr_m;
        e.done = clr_m && (ptr_m == NM - 1);
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wr_en   = 0;
        rd_en   = '0;
        clr_req = 0;
    endtask

    task automatic rand_inputs(input bit allow_clr);
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 4'($urandom);
        wr_be   = 4'($urandom);
        din     = $urandom;
        rd_en   = 2'($urandom);
        rd_addr = 8'($urandom);
        clr_req = allow_clr && ($urandom_range(0, 39) == 0);
    endtask

    task automatic drain_clear();
        idle_inputs();
        for (int g = 0; g < 40 && clr_m; g++) step();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_valid", 64'(rd_valid), 64'(e.vld));
            for (int p = 0; p < R; p++)
                chk($sformatf("dout[%0d]", p), 64'(dout[p*W +: W]), 64'(e.dout[p*W +: W]));
            chk("clr_busy", 64'(clr_busy), 64'(e.busy));
            chk("clr_done", 64'(clr_done), 64'(e.done));
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (|s_rd_valid) begin
            if (q12.size() == 0) begin
                chk("n12 unexpected rd_valid", 64'(s_rd_valid), 64'(0));
            end else begin
                e = q12.pop_front();
                chk("n12 rd_valid", 64'(s_rd_valid), 64'(e.vld));
                for (int p = 0; p < R; p++)
                    if (e.vld[p])
                        chk($sformatf("n12 dout[%0d]", p), 64'(s_dout[p*W +: W]),
                            64'(e.dout[p*W +: W]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1);
    end

    initial begin
        exp_t e12;
        rst_n = 0;
        wr_addr = '0; wr_be = '0; din = '0; rd_addr = '0;
        idle_inputs();
        s_wr_en = 0; s_wr_addr = '0; s_wr_be = '0; s_din = '0;
        s_rd_en = '0; s_rd_addr = '0; s_clr_req = 0;
        e12.busy = 0;
        e12.done = 0;
        model_reset();

        #12;
        chk("reset dout", 64'(dout), 64'(0));
        chk("reset rd_valid", 64'(rd_valid), 64'(0));
        chk("reset clr_busy", 64'(clr_busy), 64'(0));
        chk("reset clr_done", 64'(clr_done), 64'(0));
        @(negedge clk);
        rst_n = 1;
        tick();

        for (int a = 0; a < NM; a++) begin
            rd_en   = 2'b11;
            rd_addr = {4'(15 - a), 4'(a)};
            step();
        end
        idle_inputs();
        step();

        wr_en = 1; wr_addr = 4'd3; wr_be = 4'hF; din = 32'hDEADBEEF; step();
        wr_be = 4'b0010; din = 32'h0000AA00; step();
        wr_en = 0; rd_en = 2'b01; rd_addr = {4'd0, 4'd3}; step();
        idle_inputs(); step();

        wr_en = 1; wr_addr = 4'd5; wr_be = 4'hF; din = 32'hAABBCCDD; step();
        wr_be = 4'b0101; din = 32'h11223344; rd_en = 2'b11; rd_addr = {4'd5, 4'd5}; step();
        wr_en = 0; step();
        idle_inputs(); step();

        repeat (300) begin
            rand_inputs(1);
            step();
        end
        drain_clear();

        for (int a = 0; a < NM; a++) begin
            wr_en = 1; wr_addr = 4'(a); wr_be = 4'hF; din = 32'(a + 1); rd_en = '0;
            step();
        end
        wr_en = 0; clr_req = 1; step();
        clr_req = 0;
        repeat (NM) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom); wr_be = 4'hF;
            din = $urandom; rd_en = 2'b11; rd_addr = {4'($urandom), 4'd10};
            step();
        end
        idle_inputs();
        for (int a = 0; a < NM; a++) begin
            rd_en = 2'b11; rd_addr = {4'(a), 4'(a)};
            step();
        end

        clr_req = 1;
        repeat (40) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom); wr_be = 4'($urandom);
            din = $urandom; rd_en = 2'($urandom); rd_addr = 8'($urandom);
            step();
        end
        drain_clear();

        for (int a = 0; a < NM; a++) begin
            wr_en = 1; wr_addr = 4'(a); wr_be = 4'hF; din = $urandom;
            step();
        end
        wr_en = 0; rd_en = 2'b11; rd_addr = {4'd2, 4'd9}; clr_req = 1; step();
        clr_req = 0; rd_en = 2'b11; rd_addr = {4'd12, 4'd1};
        for (int g = 0; g < 20 && !(clr_m && ptr_m == 7); g++) step();
        chk("clear reached ptr 7", 64'(clr_busy), 64'(1));
        rst_n = 0;
        #1;
        chk("mid-clear reset clr_busy", 64'(clr_busy), 64'(0));
        chk("mid-clear reset clr_done", 64'(clr_done), 64'(0));
        chk("mid-clear reset dout", 64'(dout), 64'(0));
        chk("mid-clear reset rd_valid", 64'(rd_valid), 64'(0));
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
        for (int a = 0; a < NM; a++) begin
            rd_en = 2'b11; rd_addr = {4'(NM - 1 - a), 4'(a)};
            step();
        end
        idle_inputs();
        step();

        s_wr_en = 1; s_wr_addr = 4'd13; s_wr_be = 4'hF; s_din = 32'h12345678; tick();
        s_wr_addr = 4'd11; s_din = 32'hCAFEF00D; tick();
        s_wr_en = 0; s_rd_en = 2'b11; s_rd_addr = {4'd11, 4'd13};
        e12.vld = 2'b11; e12.dout = {32'hCAFEF00D, 32'h0}; q12.push_back(e12); tick();
        s_rd_addr = {4'd12, 4'd1};
        e12.vld = 2'b11; e12.dout = {32'h0, 32'h0}; q12.push_back(e12); tick();
        s_wr_en = 1; s_wr_addr = 4'd11; s_wr_be = 4'b1000; s_din = 32'hAB000000;
        s_rd_en = 2'b01; s_rd_addr = {4'd0, 4'd11};
        e12.vld = 2'b01; e12.dout = {32'h0, 32'hABFEF00D}; q12.push_back(e12); tick();
        s_wr_en = 0; s_rd_en = '0; tick();
        tick();

        chk("scoreboard drained", 64'(q.size()), 64'(0));
        chk("n12 scoreboard drained", 64'(q12.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_mp_sync.md
Name: register_file_mp_sync

Overview:
Parametrised multi-port register file with synchronous (registered) read ports. It has one write port with per-byte write enables and write-first bypass. A built-in sequential clear engine zeroes the array on request. This is the next-generation storage block for datapath register banks that need more than two read ports and a fixed one-cycle read latency.

Parameters:
M, 4, address bits per port
N, 16, number of words; N <= 2^M (N < 2^M allowed)
W, 32, word width in bits; must be a multiple of 8
R, 2, number of read ports (1..8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_addr  input  M  write address
wr_be  input  W/8  byte enables; bit k covers din[8k+7:8k]
din  input  W  write data
rd_en  input  R  per-port read enable
rd_addr  input  R*M  packed read addresses; port i at [i*M +: M]
dout  output  R*W  packed registered read data; port i at [i*W +: W]
rd_valid  output  R  per-port: dout[i] updated by previous-cycle read
clr_req  input  1  start full-array clear (level sampled in IDLE)
clr_busy  output  1  clear engine active
clr_done  output  1  one-cycle pulse on final clear write

Behaviour:
- Reset (rst_n=0, async): every array entry = 0; dout = 0; rd_valid = 0; clr_busy = 0; clr_done = 0; FSM = IDLE; clear pointer = 0.
- Write (IDLE): at the edge, if wr_en, wr_addr < N and wr_be[k]=1, byte k of entry wr_addr is replaced by din byte k. Other bytes are kept. wr_be = 0 is a no-op.
- wr_addr >= N: write dropped, no side effects.
- Read latency is 1 cycle. At the edge with rd_en[i]=1, dout[i] <= entry[rd_addr[i]] and rd_valid[i] <= 1. With rd_en[i]=0, dout[i] holds its value and rd_valid[i] <= 0.
- rd_addr[i] >= N returns 0 with rd_valid[i]=1.
- Bypass (write-first, per byte): a read and an accepted write to the same address in the same cycle returns the merged word. Enabled bytes come from din, the others from the old contents. All R ports may hit the same address; each sees the merged word.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at the edge. Pointer = 0, and clr_busy goes to 1 in the next cycle.
  - In CLEAR, each cycle entry[ptr] <= 0 and ptr increments.
  - When ptr = N-1: the final entry is zeroed, clr_done=1 for that cycle (combinational from state and ptr), and the FSM returns to IDLE with clr_busy <= 0.
  - Total CLEAR duration is N cycles.
- In CLEAR:
  - wr_en is ignored: the write is dropped, with no queueing.
  - clr_req is ignored.
  - Reads are still served. An entry with index < ptr reads 0. The entry equal to ptr reads 0 (bypass). An entry with index > ptr reads its old contents.
- clr_req and wr_en in the same IDLE cycle: the write is performed that cycle, and CLEAR starts next cycle. The end state is all zero.
- Reset asserted mid-CLEAR: immediate return to IDLE with the array zeroed. No clr_done pulse.
- clr_req held high: a new CLEAR starts in the first IDLE cycle after the previous one completes.

Decomposition:
- Package regfile_pkg holds:
  - the state typedef enum {IDLE, CLEAR};
  - the function that computes the byte-merged word from (old, din, be).
- Sub-module regfile_clear_fsm owns the state, pointer, clr_busy and clr_done. It exports clr_active, clr_ptr and clr_last.
- The top level holds the array, the write/byte-merge logic, and R generate-loop read ports.

Test Plan:
- Reset, then read all 16 addresses on both ports -> dout=0, rd_valid=1 one cycle after each rd_en.
- Write 0xDEADBEEF to addr 3 with be=4'hF, then be=4'b0010 with din=0x0000AA00. Read addr 3 -> 0xDEADAAEF, exactly one cycle after rd_en.
- Same-cycle write of 0x11223344 (be=4'b0101) to addr 5, which holds 0xAABBCCDD, while ports 0 and 1 both read addr 5 -> both dout=0xAA22CC44.
- Fill all entries with addr+1, then pulse clr_req:
  - clr_busy high for 16 cycles; clr_done on the 16th.
  - A read of addr 10 at ptr=4 returns 0x0000000B; at ptr=12 it returns 0.
  - wr_en during CLEAR has no effect; all reads afterwards return 0.
- Deassert rst_n at ptr=7 during CLEAR -> clr_busy=0 and dout=0 immediately. No clr_done. All entries 0 after release.
- With N=12, M=4: write to addr 13 is dropped; a read of addr 13 returns 0 with rd_valid=1; addr 11 behaves normally.
